op_sequencer: RTL and testbench

OP_SEQUENCER -- requirements
Module: op_sequencer

---
 rtl/op_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_op_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/op_sequencer.sv
// rtl/op_sequencer.sv - batch operand sequencer feeding an external compute unit
//
// Purpose: accepts a batch of operand pairs, drives them (registered) into a
// one-cycle-latency compute unit together with the batch opcode, and buffers
// the unit results in a credit-protected FIFO that feeds the result stream.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   start, len, op        batch start request; element count and opcode sampled with start
//   busy, done            high outside IDLE; one-cycle batch-complete pulse
//   a_valid/a_ready       operand-pair stream (a_data1, a_data2)
//   u_in1, u_in2, u_cmd   registered drive into the compute unit
//   u_out                 compute-unit result, valid one edge after u_* are presented
//   r_valid/r_ready       result stream (r_data = FIFO head)
module op_sequencer #(
  parameter int NUM_SIZE      = 32,
  parameter int CMD_SIZE_LOG2 = 2,
  parameter int DEPTH         = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [15:0]                     len,
  input  logic [2**CMD_SIZE_LOG2-1:0]     op,
  output logic                            busy,
  output logic                            done,
  input  logic                            a_valid,
  output logic                            a_ready,
  input  logic signed [NUM_SIZE-1:0]      a_data1,
  input  logic signed [NUM_SIZE-1:0]      a_data2,
  output logic signed [NUM_SIZE-1:0]      u_in1,
  output logic signed [NUM_SIZE-1:0]      u_in2,
  output logic [2**CMD_SIZE_LOG2-1:0]     u_cmd,
  input  logic signed [NUM_SIZE-1:0]      u_out,
  output logic                            r_valid,
  input  logic                            r_ready,
  output logic signed [NUM_SIZE-1:0]      r_data
);

  localparam int CW    = 2**CMD_SIZE_LOG2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CW-1:0]    OP_NOOP = '0;
  localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              op_q, op_d;
  logic [15:0]                len_q, len_d;
  logic [15:0]                accepted_q, accepted_d;
  logic [15:0]                popped_q, popped_d;
  logic                       done_q, done_d;
  logic                       v1_q, v1_d;
  logic                       v2_q, v2_d;
  logic signed [NUM_SIZE-1:0] u_in1_q, u_in1_d;
  logic signed [NUM_SIZE-1:0] u_in2_q, u_in2_d;
  logic [CW-1:0]              u_cmd_q, u_cmd_d;
  logic signed [NUM_SIZE-1:0] mem_q [DEPTH];
  logic signed [NUM_SIZE-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;

  logic [CNT_W:0] occupancy;
  logic           a_ready_int;
  logic           accept;
  logic           push;
  logic           pop;

  // Results still in the unit pipeline hold a FIFO credit, so a full FIFO
  // plus in-flight work can never exceed DEPTH.
  always_comb begin
    occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, v1_q} + {{CNT_W{1'b0}}, v2_q};
    a_ready_int = (state_q == ISSUE) && (accepted_q < len_q) && (occupancy < DEPTH_W);
    accept      = a_valid && a_ready_int;
    push        = v2_q;
    pop         = (count_q != '0) && r_ready;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    accepted_d = accepted_q;
    popped_d   = pop ? popped_q + 16'd1 : popped_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != 16'd0) begin
            op_d       = op;
            len_d      = len;
            accepted_d = 16'd0;
            popped_d   = 16'd0;
            state_d    = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (accept) begin
          accepted_d = accepted_q + 16'd1;
          if (accepted_q == len_q - 16'd1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (popped_q == len_q - 16'd1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Unit drive is zeroed with a NOOP on idle cycles so the unit never sees stale operands.
  always_comb begin
    v1_d    = accept;
    v2_d    = v1_q;
    u_in1_d = accept ? a_data1 : '0;
    u_in2_d = accept ? a_data2 : '0;
    u_cmd_d = accept ? op_q : OP_NOOP;
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = u_out;
    end
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_NOOP;
      len_q      <= 16'd0;
      accepted_q <= 16'd0;
      popped_q   <= 16'd0;
      done_q     <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      u_in1_q    <= '0;
      u_in2_q    <= '0;
      u_cmd_q    <= OP_NOOP;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_q      <= len_d;
      accepted_q <= accepted_d;
      popped_q   <= popped_d;
      done_q     <= done_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      u_in1_q    <= u_in1_d;
      u_in2_q    <= u_in2_d;
      u_cmd_q    <= u_cmd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign a_ready = a_ready_int;
  assign u_in1   = u_in1_q;
  assign u_in2   = u_in2_q;
  assign u_cmd   = u_cmd_q;
  assign r_valid = (count_q != '0);
  assign r_data  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_op_sequencer.sv
// tb/tb_op_sequencer.sv - directed self-checking bench for op_sequencer
module tb_op_sequencer;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [15:0]        len;
  logic [3:0]         op;
  logic               busy;
  logic               done;
  logic               a_valid;
  logic               a_ready;
  logic signed [31:0] a_data1;
  logic signed [31:0] a_data2;
  logic signed [31:0] u_in1;
  logic signed [31:0] u_in2;
  logic [3:0]         u_cmd;
  logic signed [31:0] u_out;
  logic               r_valid;
  logic               r_ready;
  logic signed [31:0] r_data;

  int checks = 0;
  int errors = 0;
  int idx    = 0;

  logic signed [31:0] a1_v  [8];
  logic signed [31:0] a2_v  [8];
  logic signed [31:0] exp_v [8];

  always #5 clk = ~clk;

  op_sequencer #(.NUM_SIZE(32), .CMD_SIZE_LOG2(2), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .op(op),
    .busy(busy), .done(done),
    .a_valid(a_valid), .a_ready(a_ready), .a_data1(a_data1), .a_data2(a_data2),
    .u_in1(u_in1), .u_in2(u_in2), .u_cmd(u_cmd), .u_out(u_out),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data)
  );

  // Compute unit: one-edge latency, ADD sums, anything else yields 0.
  always @(posedge clk) begin
    if (reset) u_out <= '0;
    else       u_out <= (u_cmd == 4'd1) ? u_in1 + u_in2 : 32'sd0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int i, input logic signed [31:0] x, input logic signed [31:0] y,
                      input logic signed [31:0] e);
    a1_v[i]  = x;
    a2_v[i]  = y;
    exp_v[i] = e;
  endtask

  task automatic begin_batch(input logic [15:0] l, input logic [3:0] o);
    start = 1'b1;
    len   = l;
    op    = o;
    step();
    start = 1'b0;
    idx   = 0;
  endtask

  // Feeds remaining operands from idx and collects n results in order, until done.
  task automatic run_collect(input string tag, input int n, input int max_cycles);
    int  nres  = 0;
    int  dones = 0;
    int  cyc   = 0;
    logic acc;
    logic pp;
    r_ready = 1'b1;
    if (idx < n) begin
      a_valid = 1'b1;
      a_data1 = a1_v[idx];
      a_data2 = a2_v[idx];
    end else begin
      a_valid = 1'b0;
    end
    while (!(nres == n && dones > 0) && cyc < max_cycles) begin
      acc = a_valid && a_ready;
      pp  = r_valid && r_ready;
      if (pp) begin
        if (nres < n) chk({tag, "_result"}, r_data, exp_v[nres]);
        else          chk({tag, "_extra_result"}, nres + 1, n);
        nres++;
      end
      step();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < n) begin
          a_data1 = a1_v[idx];
          a_data2 = a2_v[idx];
        end else begin
          a_valid = 1'b0;
        end
      end
      if (done) dones++;
    end
    chk({tag, "_result_count"}, nres, n);
    chk({tag, "_done_seen"}, dones, 1);
    chk({tag, "_busy_after"}, busy, 0);
    a_valid = 1'b0;
    step();
    chk({tag, "_done_single"}, done, 0);
    r_ready = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    len     = 16'd0;
    op      = 4'd0;
    a_valid = 1'b0;
    a_data1 = '0;
    a_data2 = '0;
    r_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_u_cmd", u_cmd, 0);
    chk("rst_u_in1", u_in1, 0);
    chk("rst_u_in2", u_in2, 0);
    chk("rst_r_data", r_data, 0);
    reset = 1'b0;
    step();

    // Zero-length batch: done next cycle, never busy
    begin_batch(16'd0, 4'd1);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_a_ready", a_ready, 0);
    step();
    chk("len0_done_off", done, 0);
    chk("len0_busy2", busy, 0);
    chk("len0_a_ready2", a_ready, 0);

    // Basic ADD batch with exact latency
    begin_batch(16'd3, 4'd1);
    r_ready = 1'b1;
    chk("b1_a_ready", a_ready, 1);
    a_valid = 1'b1; a_data1 = 32'sd1;   a_data2 = 32'sd2;
    step();
    chk("b1_rv_e0", r_valid, 0);
    a_data1 = 32'sd5;   a_data2 = -32'sd7;
    step();
    chk("b1_rv_e1", r_valid, 0);
    a_data1 = 32'sd100; a_data2 = 32'sd200;
    step();
    a_valid = 1'b0;
    chk("b1_rv_e2", r_valid, 1);
    chk("b1_r0", r_data, 32'd3);
    chk("b1_busy", busy, 1);
    step();
    chk("b1_r1", r_data, -32'sd2);
    step();
    chk("b1_r2", r_data, 32'd300);
    chk("b1_done_early", done, 0);
    step();
    chk("b1_done", done, 1);
    chk("b1_idle", busy, 0);
    chk("b1_empty", r_valid, 0);
    step();
    chk("b1_done_off", done, 0);
    r_ready = 1'b0;

    // Backpressure: credit limit of 4 including in-flight results
    for (int i = 0; i < 8; i++) load(i, i, 10 * i, 11 * i);
    begin_batch(16'd8, 4'd1);
    a_valid = 1'b1;
    a_data1 = a1_v[0];
    a_data2 = a2_v[0];
    for (int c = 0; c < 10; c++) begin
      logic acc;
      acc = a_valid && a_ready;
      step();
      if (acc) begin
        idx++;
        a_data1 = a1_v[idx];
        a_data2 = a2_v[idx];
      end
    end
    chk("bp_accepts", idx, 4);
    chk("bp_a_ready", a_ready, 0);
    chk("bp_r_valid", r_valid, 1);
    run_collect("bp", 8, 200);

    // Wrap-around add, then NOOP batch
    load(0, 32'sh7FFFFFFF, 32'sd1, 32'sh80000000);
    begin_batch(16'd1, 4'd1);
    run_collect("wrap", 1, 50);
    load(0, 32'sd7, 32'sd8, 32'sd0);
    load(1, 32'sd9, 32'sd10, 32'sd0);
    begin_batch(16'd2, 4'd0);
    run_collect("noop", 2, 50);

    // Reset mid-batch with two results buffered
    for (int i = 0; i < 4; i++) load(i, i + 1, i + 1, 2 * (i + 1));
    begin_batch(16'd4, 4'd1);
    a_valid = 1'b1; a_data1 = a1_v[0]; a_data2 = a2_v[0];
    step();
    a_data1 = a1_v[1]; a_data2 = a2_v[1];
    step();
    a_valid = 1'b0;
    step();
    step();
    chk("abort_buffered", r_valid, 1);
    chk("abort_busy_pre", busy, 1);
    chk("abort_head", r_data, 32'd2);
    reset = 1'b1;
    step();
    chk("abort_r_valid", r_valid, 0);
    chk("abort_u_cmd", u_cmd, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    reset = 1'b0;
    step();
    chk("abort_no_done", done, 0);
    chk("abort_still_empty", r_valid, 0);

    // Start while busy is ignored
    load(0, -32'sd1, -32'sd1, -32'sd2);
    load(1, 32'sd1000, -32'sd1, 32'sd999);
    load(2, 32'sh40000000, 32'sh40000000, 32'sh80000000);
    begin_batch(16'd3, 4'd1);
    start = 1'b1; len = 16'd5; op = 4'd0;
    step();
    start = 1'b0;
    chk("restart_busy", busy, 1);
    run_collect("restart", 3, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
